// File: rtl/interrupt_input_conditioner_pkg.sv
// Shared constants and channel FSM encoding for the RhythmGameboy input front end.
package rhythm_io_pkg;

  localparam int INT_WIDTH          = 20;
  localparam int DEF_PRESCALE       = 50000;
  localparam int DEF_DEBOUNCE_TICKS = 8;
  localparam int DEF_HOLD_CYCLES    = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_REL = 2'd2
  } chan_state_t;

  // One extra bit over $clog2 so a count of exactly max_count-1 always fits.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage

// File: rtl/interrupt_input_conditioner_if.sv
// Pin-side bundle of the interrupt input conditioner: raw pins and acknowledges in, events and levels out.
interface interrupt_input_conditioner_if
  import rhythm_io_pkg::*;
#(
  parameter int WIDTH = INT_WIDTH
);

  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] clear;
  logic [WIDTH-1:0] interrupt;
  logic [WIDTH-1:0] level;

  modport master (output raw_in, output clear, input interrupt, input level);
  modport slave  (input raw_in, input clear, output interrupt, output level);

endinterface

// File: rtl/interrupt_input_conditioner_debounce_cell.sv
// One input channel: 2-flop sync, tick-driven debounce, rise detect and pulse-stretch FSM.
// STICKY_EVENT_EN keeps the event high after the stretch until clear is seen.
module debounce_cell
  import rhythm_io_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic raw_in,
  input  logic clear,
  output logic interrupt,
  output logic level
);

  localparam int CW = cnt_width(DEBOUNCE_TICKS);
  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic          sync1_r, sync2_r;
  logic          stable_r, stable_d_r, level_r, int_r;
  logic [CW-1:0] cnt_r;
  logic [HW-1:0] hcnt_r, hcnt_s;
  chan_state_t   state_r, state_s;
  logic          rise_s, expire_s, event_s;

  // synchroniser for the asynchronous pin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw_in;
      sync2_r <= sync1_r;
    end
  end

  // debounce counter, stable level and its delayed copy for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_r   <= 1'b0;
      stable_d_r <= 1'b0;
      level_r    <= 1'b0;
      cnt_r      <= {CW{1'b0}};
    end else begin
      stable_d_r <= stable_r;
      level_r    <= stable_r;
      if (tick) begin
        if (sync2_r == stable_r) begin
          cnt_r <= {CW{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
          stable_r <= sync2_r;
          cnt_r    <= {CW{1'b0}};
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end
    end
  end

  assign rise_s = stable_r & ~stable_d_r;

  // next-state logic; a rise always (re)arms the full stretch
  always_comb begin
    state_s  = state_r;
    hcnt_s   = hcnt_r;
    expire_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          state_s = HOLD;
          hcnt_s  = HOLD_LAST;
        end else begin
          state_s = IDLE;
        end
      end
      HOLD: begin
        if (rise_s) begin
          hcnt_s = HOLD_LAST;
        end else if (hcnt_r == {HW{1'b0}}) begin
          expire_s = 1'b1;
          state_s  = stable_r ? WAIT_REL : IDLE;
        end else begin
          hcnt_s = hcnt_r - HW'(1);
        end
      end
      WAIT_REL: begin
        if (rise_s) begin
          state_s = HOLD;
          hcnt_s  = HOLD_LAST;
        end else if (!stable_r) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_REL;
        end
      end
      default: begin
        state_s = IDLE;
        hcnt_s  = {HW{1'b0}};
      end
    endcase
  end

`ifdef STICKY_EVENT_EN
  logic sticky_r, sticky_s;

  // sticky flag: expiry sets it and wins over a coincident clear
  always_comb begin
    if (expire_s) begin
      sticky_s = 1'b1;
    end else if (clear) begin
      sticky_s = 1'b0;
    end else begin
      sticky_s = sticky_r;
    end
  end

  // sticky flag register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_r <= 1'b0;
    end else begin
      sticky_r <= sticky_s;
    end
  end

  assign event_s = (state_s == HOLD) | sticky_s;
`else
  logic unused_s;
  assign unused_s = clear ^ expire_s;
  assign event_s  = (state_s == HOLD);
`endif

  // FSM state, hold counter and registered event output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      hcnt_r  <= {HW{1'b0}};
      int_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      hcnt_r  <= hcnt_s;
      int_r   <= event_s;
    end
  end

  assign interrupt = int_r;
  assign level     = level_r;

endmodule

// File: rtl/interrupt_input_conditioner.sv
// Drives the core interrupt bus from raw pins: one shared debounce prescaler plus WIDTH debounce_cell channels.
// Optional STICKY_EVENT_EN makes events latch until acknowledged via clear.
module interrupt_input_conditioner
  import rhythm_io_pkg::*;
#(
  parameter int WIDTH          = INT_WIDTH,
  parameter int PRESCALE       = DEF_PRESCALE,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES
) (
  input logic                         clk,
  input logic                         reset_n,
  interrupt_input_conditioner_if.slave bus
);

  localparam int PW = cnt_width(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    pre_r;
  logic             tick_s;
  logic [WIDTH-1:0] int_s;
  logic [WIDTH-1:0] lvl_s;

  // free-running debounce sample prescaler
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_r <= {PW{1'b0}};
    end else if (pre_r == PRE_LAST) begin
      pre_r <= {PW{1'b0}};
    end else begin
      pre_r <= pre_r + PW'(1);
    end
  end

  assign tick_s = (pre_r == PRE_LAST);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_cell #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_cell (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick      (tick_s),
      .raw_in    (bus.raw_in[i]),
      .clear     (bus.clear[i]),
      .interrupt (int_s[i]),
      .level     (lvl_s[i])
    );
  end

  assign bus.interrupt = int_s;
  assign bus.level     = lvl_s;

endmodule

// File: tb/tb_interrupt_input_conditioner.sv
// Directed bench for interrupt_input_conditioner with PRESCALE=4, DEBOUNCE_TICKS=3, HOLD_CYCLES=10.
// Sample j is taken 1 ns after the j-th clock edge following reset release.
module tb_interrupt_input_conditioner;

  localparam int W = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  interrupt_input_conditioner_if #(.WIDTH(W)) bus ();

  interrupt_input_conditioner #(
    .WIDTH          (W),
    .PRESCALE       (4),
    .DEBOUNCE_TICKS (3),
    .HOLD_CYCLES    (10)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 ns after edge 0: prescaler count is 0, first tick is evaluated at edge 4.
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, hc, seen, rises, diffs, others;
    logic prev;
    bus.raw_in = '0;
    bus.clear  = '0;
    #1;
    check_eq("reset_interrupt", bus.interrupt, 32'h0);
    check_eq("reset_level", bus.level, 32'h0);

    // 1: steady press from reset release; 2 sync + 3 ticks (edges 4,8,12) + 1 level reg = sample 13
    do_reset();
    bus.raw_in[0] = 1'b1;
    lat = 0;
    for (int j = 1; j <= 20 && lat == 0; j++) begin
      step();
      if (bus.level[0]) lat = j;
    end
    check_eq("t1_level_latency", lat, 13);
    check_eq("t1_int_with_level", bus.interrupt[0], 1);
    hc = 1;
    for (int k = 0; k < 30; k++) begin
      step();
      if (bus.interrupt[0]) hc++;
    end
    check_eq("t1_pulse_width", hc, 10);
    check_eq("t1_int_low_held", bus.interrupt[0], 0);
    check_eq("t1_level_held", bus.level[0], 1);

    // 2: bounce every clk; ticks only ever see the low phase, so nothing is accepted
    bus.raw_in = '0;
    do_reset();
    bus.raw_in[3] = 1'b1;
    seen = 0;
    for (int j = 1; j <= 60; j++) begin
      step();
      if (bus.level[3] || bus.interrupt[3]) seen++;
      bus.raw_in[3] = (j < 40) && (j % 2 == 0);
    end
    check_eq("t2_bounce_quiet", seen, 0);

    // 3: 6-clk glitch gives only two agreeing ticks; then a 20-clk press gives one pulse
    do_reset();
    bus.raw_in[5] = 1'b1;
    seen = 0;
    rises = 0;
    hc = 0;
    prev = 1'b0;
    for (int j = 1; j <= 100; j++) begin
      step();
      if (j <= 40 && (bus.level[5] || bus.interrupt[5])) seen++;
      if (bus.interrupt[5] && !prev) rises++;
      if (bus.interrupt[5]) hc++;
      prev = bus.interrupt[5];
      bus.raw_in[5] = (j < 6) || (j >= 41 && j <= 60);
    end
    check_eq("t3_glitch_quiet", seen, 0);
    check_eq("t3_press_rises", rises, 1);
    check_eq("t3_press_width", hc, 10);
    check_eq("t3_level_released", bus.level[5], 0);

    // 4: coincident presses on bits 0, 7, 19
    bus.raw_in = '0;
    do_reset();
    bus.raw_in = 20'h80081;
    diffs = 0;
    others = 0;
    hc = 0;
    for (int j = 1; j <= 50; j++) begin
      step();
      if (j == 13) check_eq("t4_vector", bus.interrupt, 32'h80081);
      if ((bus.interrupt & ~20'h80081) != 20'h0) others++;
      if (bus.interrupt[0] != bus.interrupt[7] || bus.interrupt[7] != bus.interrupt[19]) diffs++;
      if (bus.interrupt[0]) hc++;
    end
    check_eq("t4_others_quiet", others, 0);
    check_eq("t4_coincident", diffs, 0);
    check_eq("t4_width", hc, 10);
    check_eq("t4_levels", bus.level, 32'h80081);

    // 5: reset during the 4th clk of a pulse, input kept high
    bus.raw_in = '0;
    do_reset();
    bus.raw_in[0] = 1'b1;
    lat = 0;
    for (int j = 1; j <= 20 && lat == 0; j++) begin
      step();
      if (bus.interrupt[0]) lat = j;
    end
    check_eq("t5_first_pulse", lat, 13);
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    check_eq("t5_async_int", bus.interrupt, 32'h0);
    check_eq("t5_async_level", bus.level, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    lat = 0;
    hc = 0;
    rises = 0;
    prev = 1'b0;
    for (int j = 1; j <= 60; j++) begin
      step();
      if (bus.interrupt[0] && lat == 0) lat = j;
      if (bus.interrupt[0] && !prev) rises++;
      if (bus.interrupt[0]) hc++;
      prev = bus.interrupt[0];
    end
    check_eq("t5_repulse_latency", lat, 13);
    check_eq("t5_repulse_count", rises, 1);
    check_eq("t5_repulse_width", hc, 10);

`ifdef STICKY_EVENT_EN
    // 6: sticky event; release at 24 drops stable at edge 36, re-press at 37 rises at edge 48
    bus.raw_in = '0;
    do_reset();
    bus.raw_in[2] = 1'b1;
    for (int j = 1; j <= 60; j++) begin
      step();
      if (j == 23) check_eq("t6_sticky_after_hold", bus.interrupt[2], 1);
      if (j == 30) check_eq("t6_sticky_held", bus.interrupt[2], 1);
      if (j == 31) check_eq("t6_clear_drops", bus.interrupt[2], 0);
      if (j == 48) check_eq("t6_idle_before_rise", bus.interrupt[2], 0);
      if (j == 49) check_eq("t6_clear_vs_rise", bus.interrupt[2], 1);
      bus.raw_in[2] = (j < 24) || (j >= 37);
      bus.clear[2]  = (j == 30) || (j == 48);
    end
    bus.clear = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
